// File: rtl/tile_pkg.sv
// Shared constants, FSM encoding and a small helper for the tile fill engine.
package tile_pkg;

  localparam int TILE_W   = 40;
  localparam int TILE_H   = 30;
  localparam int SCREEN_H = 120;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Row is drawable only when it lies above the bottom edge of the screen.
  function automatic logic row_visible(input logic [7:0] row, input int screen_h);
    return (int'(row) < screen_h);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order xc/yc counter; exposes its next-state values so the pixel
// address can be registered in the same cycle the counter moves.
module raster_counter
  import tile_pkg::*;
#(
  parameter int W  = TILE_W,
  parameter int H  = TILE_H,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [XW-1:0] xc_nxt_o,
  output logic [YW-1:0] yc_nxt_o,
  output logic          last_o
);

  logic [XW-1:0] xc_q, xc_d;
  logic [YW-1:0] yc_q, yc_d;

  always_comb begin
    xc_d = xc_q;
    yc_d = yc_q;
    if (clr_i) begin
      xc_d = '0;
      yc_d = '0;
    end else if (en_i) begin
      if (xc_q == XW'(W - 1)) begin
        xc_d = '0;
        yc_d = (yc_q == YW'(H - 1)) ? '0 : yc_q + 1'b1;
      end else begin
        xc_d = xc_q + 1'b1;
      end
    end else begin
      xc_d = xc_q;
      yc_d = yc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xc_q <= '0;
      yc_q <= '0;
    end else begin
      xc_q <= xc_d;
      yc_q <= yc_d;
    end
  end

  assign xc_nxt_o = xc_d;
  assign yc_nxt_o = yc_d;
  assign last_o   = (xc_q == XW'(W - 1)) && (yc_q == YW'(H - 1));

endmodule

// File: rtl/tile_draw_engine.sv
// Fills one TILE_W x TILE_H rectangle, one registered pixel per cycle, with
// rows at or below SCREEN_H suppressed but still timed.
module tile_draw_engine
  import tile_pkg::*;
#(
  parameter int TILE_W   = tile_pkg::TILE_W,
  parameter int TILE_H   = tile_pkg::TILE_H,
  parameter int SCREEN_H = tile_pkg::SCREEN_H
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  col,
  input  logic [6:0]  y_top,
  input  logic [23:0] color,
  output logic        busy,
  output logic        done,
  output logic [7:0]  VGA_X,
  output logic [6:0]  VGA_Y,
  output logic [23:0] VGA_COLOR,
  output logic        plot
);

  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);

  state_e state_q, state_d;

  logic [1:0]    col_q;
  logic [6:0]    ytop_q;
  logic [23:0]   color_q;
  logic          accept_s, adv_s, last_s;
  logic [XW-1:0] xc_nxt_s;
  logic [YW-1:0] yc_nxt_s;
  logic [1:0]    col_sel_s;
  logic [6:0]    ytop_sel_s;
  logic [23:0]   color_sel_s;
  logic [7:0]    x_nxt_s, y_nxt_s;
  logic [7:0]    vga_x_q;
  logic [6:0]    vga_y_q;
  logic [23:0]   vga_color_q;
  logic          plot_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_DRAW; else state_d = ST_IDLE;
      ST_DRAW: if (last_s) state_d = ST_DONE; else state_d = ST_DRAW;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_s = 1'b0;
    adv_s    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: accept_s = start;
      ST_DRAW: begin
        busy  = 1'b1;
        adv_s = ~last_s;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        accept_s = 1'b0;
        adv_s    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      col_q   <= 2'd0;
      ytop_q  <= 7'd0;
      color_q <= 24'd0;
    end else if (accept_s) begin
      col_q   <= col;
      ytop_q  <= y_top;
      color_q <= color;
    end
  end

  raster_counter #(
    .W (TILE_W),
    .H (TILE_H)
  ) u_raster (
    .clk_i    (CLOCK_50),
    .rst_ni   (resetn),
    .clr_i    (accept_s),
    .en_i     (adv_s),
    .xc_nxt_o (xc_nxt_s),
    .yc_nxt_o (yc_nxt_s),
    .last_o   (last_s)
  );

  // On the accepting edge the live inputs feed pixel (0,0) directly, giving one-cycle latency.
  always_comb begin
    col_sel_s   = accept_s ? col   : col_q;
    ytop_sel_s  = accept_s ? y_top : ytop_q;
    color_sel_s = accept_s ? color : color_q;
    x_nxt_s     = 8'(int'(col_sel_s) * TILE_W) + 8'(xc_nxt_s);
    y_nxt_s     = {1'b0, ytop_sel_s} + 8'(yc_nxt_s);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      vga_x_q     <= 8'd0;
      vga_y_q     <= 7'd0;
      vga_color_q <= 24'd0;
      plot_q      <= 1'b0;
    end else if (state_d == ST_DRAW) begin
      vga_x_q     <= x_nxt_s;
      vga_y_q     <= y_nxt_s[6:0];
      vga_color_q <= color_sel_s;
      plot_q      <= row_visible(y_nxt_s, SCREEN_H);
    end else begin
      plot_q      <= 1'b0;
    end
  end

  assign VGA_X     = vga_x_q;
  assign VGA_Y     = vga_y_q;
  assign VGA_COLOR = vga_color_q;
  assign plot      = plot_q;

endmodule

// File: tb/tb_tile_draw_engine.sv
// Scoreboard bench: accepted requests expand into expected plotted pixels;
// a negedge monitor checks plots, busy/done timing and reset values.
module tb_tile_draw_engine;

  localparam int TW = 40;
  localparam int TH = 30;
  localparam int SH = 120;
  localparam int DRAW_LEN = TW * TH;

  typedef struct {
    int          cyc;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        resetn, start;
  logic [1:0]  col;
  logic [6:0]  y_top;
  logic [23:0] color;
  logic        busy, done, plot;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [23:0] VGA_COLOR;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   free_at = 0;
  int   last_acc = -1;
  int   last_col = 0;
  logic [23:0] last_color = 24'd0;
  pix_t exp_q[$];

  tile_draw_engine dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .start    (start),
    .col      (col),
    .y_top    (y_top),
    .color    (color),
    .busy     (busy),
    .done     (done),
    .VGA_X    (VGA_X),
    .VGA_Y    (VGA_Y),
    .VGA_COLOR(VGA_COLOR),
    .plot     (plot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Advance one clock; if the engine is free and start is high, record the request.
  task automatic step();
    int nxt;
    nxt = cyc + 1;
    if (resetn && start && nxt >= free_at) begin
      for (int yc = 0; yc < TH; yc++) begin
        for (int xc = 0; xc < TW; xc++) begin
          pix_t p;
          int row;
          row = int'(y_top) + yc;
          if (row < SH) begin
            p.cyc = nxt + yc * TW + xc;
            p.x   = 8'(int'(col) * TW + xc);
            p.y   = 7'(row);
            p.c   = color;
            exp_q.push_back(p);
          end
        end
      end
      last_acc   = nxt;
      free_at    = nxt + DRAW_LEN + 2;
      last_col   = int'(col);
      last_color = color;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle();
    while (cyc + 1 < free_at) step();
  endtask

  task automatic apply_reset(input int n);
    resetn   = 1'b0;
    exp_q.delete();
    last_acc = -1;
    free_at  = 0;
    steps(n);
  endtask

  task automatic request(input logic [1:0] c, input logic [6:0] y, input logic [23:0] k);
    col   = c;
    y_top = y;
    color = k;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Monitor: compares DUT outputs with the model on every falling edge.
  initial begin
    pix_t p;
    logic eb, ed;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        check("reset_outputs", {busy, done, plot, VGA_X, VGA_Y},  32'd0);
        check("reset_color", {8'd0, VGA_COLOR}, 32'd0);
      end else begin
        eb = (last_acc >= 0) && (cyc >= last_acc) && (cyc <= last_acc + DRAW_LEN);
        ed = (last_acc >= 0) && (cyc == last_acc + DRAW_LEN);
        check("busy_done", {30'd0, busy, done}, {30'd0, eb, ed});
        if (plot) begin
          if (exp_q.size() == 0) begin
            check("unexpected_plot", 32'd1, 32'd0);
          end else begin
            p = exp_q.pop_front();
            check("pixel_cycle", cyc, p.cyc);
            check("pixel_xy", {17'd0, VGA_X, VGA_Y}, {17'd0, p.x, p.y});
            check("pixel_color", {8'd0, VGA_COLOR}, {8'd0, p.c});
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          check("missing_plot", 32'd0, 32'd1);
          void'(exp_q.pop_front());
        end
        if (ed) begin
          check("done_hold_x", {24'd0, VGA_X}, 32'(last_col * TW + TW - 1));
          check("done_hold_color", {8'd0, VGA_COLOR}, {8'd0, last_color});
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    start  = 1'b1;
    col    = 2'd0;
    y_top  = 7'd0;
    color  = 24'd0;
    #2;
    apply_reset(2);

    // Release with start already high: acceptance on the very first edge.
    col    = 2'd2;
    y_top  = 7'd10;
    color  = 24'hFFFFFF;
    resetn = 1'b1;
    step();
    start  = 1'b0;
    steps(300);
    col    = 2'd3;
    y_top  = 7'd5;
    color  = 24'h123456;
    start  = 1'b1;
    steps(20);
    start  = 1'b0;
    wait_idle();
    steps(3);

    request(2'd0, 7'd100, 24'hA5A5A5);
    wait_idle();
    steps(2);

    request(2'd1, 7'd20, 24'h00FF00);
    steps(500);
    apply_reset(2);
    resetn = 1'b1;
    request(2'd1, 7'd50, 24'h0F0F0F);
    wait_idle();
    steps(2);

    col   = 2'd3;
    y_top = 7'd119;
    color = 24'hC0FFEE;
    start = 1'b1;
    steps(2 * (DRAW_LEN + 2) + 2);
    start = 1'b0;
    wait_idle();
    steps(2);

    for (int i = 0; i < 6; i++) begin
      steps($urandom_range(0, 3));
      request(2'($urandom_range(0, 3)), 7'($urandom_range(0, 119)), 24'($urandom));
      steps($urandom_range(1, 1100));
      col   = 2'($urandom_range(0, 3));
      y_top = 7'($urandom_range(0, 119));
      color = 24'($urandom);
      start = 1'b1;
      steps($urandom_range(1, 4));
      start = 1'b0;
      wait_idle();
    end
    steps(3);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tile_draw_engine.md
TILE_DRAW_ENGINE -- requirements
Module: tile_draw_engine

Interface
REQ-001 Parameter TILE_W, default 40, tile width in pixels (160 / 4 columns).
REQ-002 Parameter TILE_H, default 30, tile height in pixels.
REQ-003 Parameter SCREEN_H, default 120, visible rows at 160x120 resolution.
REQ-004 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-005 resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 start  input  1  request strobe; sampled only in IDLE.
REQ-007 col  input  2  tile column 0..3.
REQ-008 y_top  input  7  top row of the tile, 0..119.
REQ-009 color  input  24  fill colour, RGB 8:8:8.
REQ-010 busy  output  1  high in DRAW and DONE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 VGA_X  output  8  pixel column to the VGA stage.
REQ-013 VGA_Y  output  7  pixel row to the VGA stage.
REQ-014 VGA_COLOR  output  24  pixel colour to the VGA stage.
REQ-015 plot  output  1  write strobe; the VGA stage writes one pixel per cycle with plot high.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, DRAW, DONE.
REQ-017 In IDLE, start=1 at an edge SHALL latch col, y_top and color, clear counters xc=0 and yc=0, and enter DRAW.
REQ-018 start SHALL be ignored in DRAW and DONE; the latched request SHALL NOT change until the next IDLE acceptance.
REQ-019 In DRAW, one pixel per cycle SHALL be emitted in raster order: xc increments 0..TILE_W-1, then wraps to 0 while yc increments.
REQ-020 Pixel address SHALL be VGA_X = col*TILE_W + xc and VGA_Y = y_top + yc, computed 8 bits wide before truncation to 7 bits.
REQ-021 The first pixel (0,0 of the tile) SHALL be presented on the cycle immediately after the accepting edge, which gives 1-cycle latency.
REQ-022 VGA_X, VGA_Y, VGA_COLOR and plot SHALL be registered outputs.
REQ-023 Clipping: when y_top + yc >= SCREEN_H, plot SHALL be 0 for that pixel. The cycle is still consumed and VGA_Y is don't-care.
REQ-024 DRAW SHALL last exactly TILE_W*TILE_H cycles (1200 at defaults), regardless of clipping.
REQ-025 After the last pixel (xc=TILE_W-1, yc=TILE_H-1), the FSM SHALL enter DONE for exactly one cycle, with done=1, plot=0 and busy=1.
REQ-026 DONE SHALL always return to IDLE. The earliest next acceptance is the cycle after DONE.
REQ-027 In IDLE and DONE, plot SHALL be 0 and VGA_X, VGA_Y and VGA_COLOR SHALL hold their last values.

Reset
REQ-028 While resetn=0, the FSM SHALL be in IDLE, and busy, done, plot, VGA_X, VGA_Y, VGA_COLOR, xc, yc and all latched request registers SHALL be 0.
REQ-029 Reset asserted during DRAW SHALL abort immediately with no done pulse.
REQ-030 After resetn is released, the first acceptance SHALL be possible at the first rising edge where resetn=1 and start=1.

Structure
REQ-031 TILE_W, TILE_H, SCREEN_H, the column count (4) and the FSM state encoding SHALL live in the shared package tile_pkg.
REQ-032 The xc/yc raster counter, with its wrap and last-pixel flag, SHALL be a sub-module named raster_counter.

Verification
REQ-033 Reset: resetn=0 for 20 ns with start=1 -> plot=0, busy=0, done=0 and all outputs 0 throughout.
REQ-034 Normal draw: start with col=2, y_top=10, color=24'hFFFFFF ->
- first pixel (80,10) one cycle later;
- last pixel (119,39);
- exactly 1200 plot cycles;
- done on cycle 1201.
REQ-035 Clipping: col=0, y_top=100 -> plot=1 for rows 100..119 only (800 pixels), 1200 DRAW cycles, done still pulses once.
REQ-036 Start while busy: assert start with col=3 mid-draw -> ignored; the pixel stream and colour stay those of the original request.
REQ-037 Reset mid-draw: resetn=0 at pixel 500 -> plot=0 and busy=0 immediately, no done pulse; a new start after release draws from (0,0) of the new tile.
REQ-038 Back-to-back: start held high continuously -> two complete draws separated by exactly one DONE cycle and one IDLE cycle.
